// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter and its picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DONE
  } arb_state_t;

  // Arbitration policy selectors
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker: fixed priority (lowest index wins) or
// rotating priority starting the search at ptr and wrapping modulo NUM_REQ.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mode,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W-1:0]   base;
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     sum;

  // Rotate requests so the search origin sits at bit 0, then take the first set bit
  always_comb begin
    base   = (mode == 1'(ARB_RR)) ? ptr : '0;
    rot    = NUM_REQ'({req, req} >> base);
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, base} + (IDX_W+1)'(i);
        if (sum >= NUM_L) sum = sum - NUM_L;
        winner = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-requester arbiter for the single memory port: registered req/ack
// handshake, transaction hold, fixed or round-robin policy.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ROUND_ROBIN = 0,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack
);

  localparam logic             RR_MODE  = (ROUND_ROBIN == ARB_RR);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [NUM_REQ-1:0] ack_vec;

  arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .mode   (RR_MODE),
    .found  (found),
    .winner (winner)
  );

  // Route the winner's request fields and form the one-hot ack for the current grant
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    ack_vec   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
      ack_vec[i] = (grant_id == IDX_W'(i));
    end
    next_ptr = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; DONE is a fixed turnaround so an acked requester can drop req
  always_comb begin
    state_n = state;
    case (state)
      ARB_IDLE: if (found)   state_n = ARB_BUSY;
      ARB_BUSY: if (mem_ack) state_n = ARB_DONE;
      ARB_DONE: state_n = ARB_IDLE;
      default:  state_n = ARB_IDLE;
    endcase
  end

  // Registered outputs: latch the grant in IDLE, hold through BUSY, pulse ack on completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack       <= '0;
      rdata     <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_ptr    <= '0;
    end else begin
      ack <= '0;
      case (state)
        ARB_IDLE: begin
          if (found) begin
            grant_id  <= winner;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        ARB_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            ack     <= ack_vec;
            rdata   <= mem_rdata;
            rr_ptr  <= next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-priority and a round-robin
// instance share the same requester and memory stimulus.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  logic [N-1:0]  f_ack, r_ack;
  logic [DW-1:0] f_rdata, r_rdata;
  logic [1:0]    f_gid, r_gid;
  logic          f_busy, r_busy, f_mreq, r_mreq, f_mwe, r_mwe;
  logic [AW-1:0] f_maddr, r_maddr;
  logic [DW-1:0] f_mwdata, r_mwdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .ROUND_ROBIN(0)) dut_fix (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(f_ack), .rdata(f_rdata), .grant_id(f_gid),
    .busy(f_busy), .mem_req(f_mreq), .mem_we(f_mwe), .mem_addr(f_maddr),
    .mem_wdata(f_mwdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  mem_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(r_ack), .rdata(r_rdata), .grant_id(r_gid),
    .busy(r_busy), .mem_req(r_mreq), .mem_we(r_mwe), .mem_addr(r_maddr),
    .mem_wdata(r_mwdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Advance one clock and settle just past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (f_mreq !== 1'b0 || f_busy !== 1'b0 || f_ack !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: mreq=%b busy=%b ack=%b, required 0 0 000", f_mreq, f_busy, f_ack); end
    n_checks++; if (f_rdata !== 32'h0 || f_gid !== 2'd0 || f_maddr !== 32'h0 || f_mwe !== 1'b0) begin n_fail++; $display("FAIL reset_data: rdata=%h gid=%0d addr=%h we=%b, required 0", f_rdata, f_gid, f_maddr, f_mwe); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    req = 3'b010;
    req_we = 3'b000;
    req_addr[AW +: AW] = 32'h0000_0040;
    tick();
    n_checks++; if (f_mreq !== 1'b1 || f_busy !== 1'b1 || f_gid !== 2'd1 || f_maddr !== 32'h40 || f_mwe !== 1'b0) begin n_fail++; $display("FAIL read_grant: mreq=%b busy=%b gid=%0d addr=%h we=%b, required 1 1 1 00000040 0", f_mreq, f_busy, f_gid, f_maddr, f_mwe); end
    n_checks++; if (f_ack !== 3'b000) begin n_fail++; $display("FAIL read_noack_early: ack=%b, required 000", f_ack); end
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (f_ack !== 3'b010 || f_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_ack: ack=%b rdata=%h, required 010 deadbeef", f_ack, f_rdata); end
    n_checks++; if (f_mreq !== 1'b0 || f_busy !== 1'b0) begin n_fail++; $display("FAIL read_release: mreq=%b busy=%b, required 0 0", f_mreq, f_busy); end
    req = 3'b000;
    mem_ack = 1'b0;
    mem_rdata = 32'h1111_2222;
    tick();
    n_checks++; if (f_ack !== 3'b000 || f_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_turnaround: ack=%b rdata=%h, required 000 deadbeef", f_ack, f_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    req = 3'b001;
    tick();
    n_checks++; if (f_mreq !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: mreq=%b, required 1", f_mreq); end
    reset = 1'b1;
    #1;
    n_checks++; if (f_mreq !== 1'b0 || f_busy !== 1'b0 || f_ack !== 3'b000) begin n_fail++; $display("FAIL midrst_async: mreq=%b busy=%b ack=%b, required 0 0 000", f_mreq, f_busy, f_ack); end
    #2;
    reset = 1'b0;
    tick();
    n_checks++; if (f_mreq !== 1'b1 || f_gid !== 2'd0 || f_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_regrant: mreq=%b gid=%0d busy=%b, required 1 0 1", f_mreq, f_gid, f_busy); end
    mem_ack = 1'b1;
    tick();
    n_checks++; if (f_ack !== 3'b001) begin n_fail++; $display("FAIL midrst_ack: ack=%b, required 001", f_ack); end
    req = 3'b000;
    mem_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_fixed_contention();
    req = 3'b111;
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (f_gid !== 2'd0 || f_mreq !== 1'b1) begin n_fail++; $display("FAIL fixed_grant[%0d]: gid=%0d mreq=%b, required 0 1", k, f_gid, f_mreq); end
      tick();
      n_checks++; if (f_ack !== 3'b001) begin n_fail++; $display("FAIL fixed_ack[%0d]: ack=%b, required 001", k, f_ack); end
      tick();
      n_checks++; if (f_ack !== 3'b000 || f_mreq !== 1'b0) begin n_fail++; $display("FAIL fixed_gap[%0d]: ack=%b mreq=%b, required 000 0", k, f_ack, f_mreq); end
    end
    req = 3'b000;
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [N-1:0] exp_a;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    req = 3'b111;
    mem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_a = 3'b001 << exp_g[k];
      tick();
      n_checks++; if (r_gid !== exp_g[k] || r_mreq !== 1'b1 || r_ack !== 3'b000) begin n_fail++; $display("FAIL rr_grant[%0d]: gid=%0d mreq=%b ack=%b, required %0d 1 000", k, r_gid, r_mreq, r_ack, exp_g[k]); end
      tick();
      n_checks++; if (r_ack !== exp_a) begin n_fail++; $display("FAIL rr_ack[%0d]: ack=%b, required %b", k, r_ack, exp_a); end
      tick();
      n_checks++; if (r_ack !== 3'b000) begin n_fail++; $display("FAIL rr_gap[%0d]: ack=%b, required 000", k, r_ack); end
    end
    req = 3'b000;
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_write_stall();
    req = 3'b100;
    req_we = 3'b100;
    req_addr[2*AW +: AW] = 32'h0000_0100;
    req_wdata[2*DW +: DW] = 32'h1234_5678;
    tick();
    n_checks++; if (f_gid !== 2'd2 || f_mwe !== 1'b1 || f_maddr !== 32'h100 || f_mwdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_grant: gid=%0d we=%b addr=%h wdata=%h, required 2 1 00000100 12345678", f_gid, f_mwe, f_maddr, f_mwdata); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (f_mreq !== 1'b1 || f_mwe !== 1'b1 || f_maddr !== 32'h100 || f_mwdata !== 32'h1234_5678 || f_ack !== 3'b000) begin n_fail++; $display("FAIL wr_stall[%0d]: mreq=%b we=%b addr=%h wdata=%h ack=%b, required 1 1 00000100 12345678 000", k, f_mreq, f_mwe, f_maddr, f_mwdata, f_ack); end
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hAAAA_5555;
    tick();
    n_checks++; if (f_ack !== 3'b100 || f_rdata !== 32'hAAAA_5555) begin n_fail++; $display("FAIL wr_ack: ack=%b rdata=%h, required 100 aaaa5555", f_ack, f_rdata); end
    mem_ack = 1'b0;
    req = 3'b000;
    req_we = 3'b000;
    tick();
    n_checks++; if (f_ack !== 3'b000) begin n_fail++; $display("FAIL wr_turnaround: ack=%b, required 000", f_ack); end
    tick();
  endtask

  task automatic test_withdraw();
    req = 3'b011;
    tick();
    n_checks++; if (f_gid !== 2'd0 || f_mreq !== 1'b1) begin n_fail++; $display("FAIL wd_grant: gid=%0d mreq=%b, required 0 1", f_gid, f_mreq); end
    req = 3'b010;
    tick();
    n_checks++; if (f_mreq !== 1'b1 || f_gid !== 2'd0) begin n_fail++; $display("FAIL wd_hold: mreq=%b gid=%0d, required 1 0", f_mreq, f_gid); end
    mem_ack = 1'b1;
    tick();
    n_checks++; if (f_ack !== 3'b001) begin n_fail++; $display("FAIL wd_ack: ack=%b, required 001", f_ack); end
    mem_ack = 1'b0;
    tick();
    tick();
    n_checks++; if (f_gid !== 2'd1 || f_mreq !== 1'b1 || f_maddr !== 32'h40) begin n_fail++; $display("FAIL wd_next: gid=%0d mreq=%b addr=%h, required 1 1 00000040", f_gid, f_mreq, f_maddr); end
    mem_ack = 1'b1;
    tick();
    n_checks++; if (f_ack !== 3'b010) begin n_fail++; $display("FAIL wd_next_ack: ack=%b, required 010", f_ack); end
    mem_ack = 1'b0;
    req = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_reset_mid_busy();
    test_fixed_contention();
    test_round_robin();
    test_write_stall();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
